// File: rtl/control_pkg.sv
// Shared definitions for the simulation test-control page.
// Contents: register offsets (selected by adr_i[3:2]), STATUS bit positions,
// dump FSM state encoding, and the Wishbone byte-lane merge helper.
package control_pkg;

    localparam int unsigned WB_DW     = 32;
    localparam int unsigned REG_OFS_W = 2;

    // Register offsets as word indices
    localparam logic [REG_OFS_W-1:0] SIG_BEGIN_OFS = 2'd0;
    localparam logic [REG_OFS_W-1:0] SIG_END_OFS   = 2'd1;
    localparam logic [REG_OFS_W-1:0] STOP_OFS      = 2'd2;
    localparam logic [REG_OFS_W-1:0] STATUS_OFS    = 2'd3;

    // STATUS register bit positions
    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

    // Dump FSM encoding
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_DUMP_ENC = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_DUMP = ST_DUMP_ENC,
        ST_DONE = ST_DONE_ENC
    } state_e;

    // Replace the byte lanes of old_val enabled by sel with those of wdat
    function automatic logic [WB_DW-1:0] wb_merge(input logic [WB_DW-1:0] old_val,
                                                  input logic [WB_DW-1:0] wdat,
                                                  input logic [3:0]       sel);
        logic [WB_DW-1:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = wdat[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sig_dumper.sv
// Signature dump engine: walks the word window [i_begin, i_end) one address
// per cycle, translates each address into a RAM word index, and presents the
// returned RAM word (or zero for addresses outside RAM) on the signature port.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   i_start             one-cycle pulse: accepted STOP write this cycle
//   i_begin, i_end      window bounds (bits [1:0] are zero)
//   o_mem_adr           RAM word index, registered
//   i_mem_dat           RAM word, valid the cycle after o_mem_adr
//   o_sig_valid         registered signature strobe
//   o_sig_data_c        signature word, combinational mux of i_mem_dat
//   o_done              registered, sticky until reset
//   o_busy_c, o_idle_c  state decode for STATUS and write blocking
module sig_dumper
    import control_pkg::*;
#(
    parameter logic [31:0] MEMORY_BASE_ADDRESS = 32'h2000_0000,
    parameter int unsigned MEMORY_SIZE         = 32'h0000_4000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             i_start,
    input  logic [31:0]                      i_begin,
    input  logic [31:0]                      i_end,
    output logic [$clog2(MEMORY_SIZE/4)-1:0] o_mem_adr,
    input  logic [31:0]                      i_mem_dat,
    output logic                             o_sig_valid,
    output logic [31:0]                      o_sig_data_c,
    output logic                             o_done,
    output logic                             o_busy_c,
    output logic                             o_idle_c
);

    localparam int unsigned MEM_AW = $clog2(MEMORY_SIZE / 4);
    localparam int unsigned CNT_W  = 30;

    state_e              r_state, w_state_nxt;
    logic [31:0]         r_addr, w_addr_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [MEM_AW-1:0]   r_mem_adr, w_mem_adr_nxt;
    logic                r_issue, w_issue_nxt;
    logic                r_issue_inr, w_issue_inr_nxt;
    logic                r_valid, r_valid_inr;
    logic                r_done, w_done_nxt;

    logic [31:0]         w_span;
    logic [CNT_W-1:0]    w_words;
    logic [31:0]         w_mem_ofs;
    logic                w_in_range;
    logic                w_unused;

    // Word count of the window; an empty or inverted window dumps nothing
    assign w_span  = i_end - i_begin;
    assign w_words = (i_end > i_begin) ? w_span[31:2] : '0;

    // Offset into RAM; unsigned compare covers both ends of the RAM range
    assign w_mem_ofs  = r_addr - MEMORY_BASE_ADDRESS;
    assign w_in_range = (w_mem_ofs < 32'(MEMORY_SIZE));

    assign w_unused = &{1'b0, w_span[1:0]};

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_cnt_nxt       = r_cnt;
        w_mem_adr_nxt   = r_mem_adr;
        w_issue_nxt     = 1'b0;
        w_issue_inr_nxt = 1'b0;
        w_done_nxt      = r_done;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_DUMP;
                    w_addr_nxt  = i_begin;
                    w_cnt_nxt   = w_words;
                end
            end
            ST_DUMP: begin
                if (r_cnt != '0) begin
                    w_issue_nxt     = 1'b1;
                    w_issue_inr_nxt = w_in_range;
                    w_mem_adr_nxt   = w_mem_ofs[MEM_AW+1:2];
                    w_addr_nxt      = r_addr + 32'd4;
                    w_cnt_nxt       = r_cnt - CNT_W'(1);
                end else if (!r_issue) begin
                    // Last address issued and its data word already out
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address stage plus one-cycle alignment stage matching RAM read latency
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_mem_adr   <= '0;
            r_issue     <= 1'b0;
            r_issue_inr <= 1'b0;
            r_valid     <= 1'b0;
            r_valid_inr <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_addr      <= w_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mem_adr   <= w_mem_adr_nxt;
            r_issue     <= w_issue_nxt;
            r_issue_inr <= w_issue_inr_nxt;
            r_valid     <= r_issue;
            r_valid_inr <= r_issue_inr;
            r_done      <= w_done_nxt;
        end
    end

    assign o_mem_adr    = r_mem_adr;
    assign o_sig_valid  = r_valid;
    // RAM data arrives in the valid cycle itself, so it cannot be registered here
    assign o_sig_data_c = (r_valid && r_valid_inr) ? i_mem_dat : 32'd0;
    assign o_done       = r_done;
    assign o_busy_c     = (r_state == ST_DUMP);
    assign o_idle_c     = (r_state == ST_IDLE);

endmodule

// File: rtl/sim_control.sv
// Test-control page of the simulation SoC: Wishbone-B4 classic slave with the
// SIG_BEGIN / SIG_END / STOP / STATUS registers, driving the signature dumper.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   cyc_i, stb_i, we_i, adr_i,
//   sel_i, dat_i                  Wishbone request
//   dat_o, ack_o, err_o, rty_o    Wishbone response (dat_o is 0 outside ack)
//   mem_adr_o, mem_dat_i          side read port into RAM
//   sig_valid_o, sig_data_o       signature word stream
//   done_o                        dump complete, sticky until reset
// Build option: CONTROL_SIM_DUMP_EN prints each signature word and ends the
// simulation on done_o.
module sim_control
    import control_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS        = 32'h3000_0000,
    parameter logic [31:0] MEMORY_BASE_ADDRESS = 32'h2000_0000,
    parameter int unsigned MEMORY_SIZE         = 32'h0000_4000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cyc_i,
    input  logic                             stb_i,
    input  logic                             we_i,
    input  logic [31:0]                      adr_i,
    input  logic [3:0]                       sel_i,
    input  logic [31:0]                      dat_i,
    output logic [31:0]                      dat_o,
    output logic                             ack_o,
    output logic                             err_o,
    output logic                             rty_o,
    output logic [$clog2(MEMORY_SIZE/4)-1:0] mem_adr_o,
    input  logic [31:0]                      mem_dat_i,
    output logic                             sig_valid_o,
    output logic [31:0]                      sig_data_o,
    output logic                             done_o
);

    logic [31:2]            r_begin;
    logic [31:2]            r_end;
    logic                   r_ack;
    logic [31:0]            r_dat;

    logic                   w_sel;
    logic                   w_req;
    logic                   w_wr;
    logic                   w_start;
    logic                   w_idle;
    logic                   w_busy;
    logic                   w_done;
    logic [REG_OFS_W-1:0]   w_ofs;
    logic [31:0]            w_begin_full;
    logic [31:0]            w_end_full;
    logic [31:0]            w_begin_nxt;
    logic [31:0]            w_end_nxt;
    logic [31:0]            w_rdata;
    logic                   w_sig_valid;
    logic [31:0]            w_sig_data;
    logic                   w_unused;

    // Address decode; ack_o low gates a new request so a held strobe is served every other cycle
    assign w_sel   = cyc_i & stb_i & (adr_i[31:4] == BASE_ADDRESS[31:4]);
    assign w_ofs   = adr_i[3:2];
    assign w_req   = w_sel & ~r_ack;
    assign w_wr    = w_req & we_i & w_idle;
    assign w_start = w_wr & (w_ofs == STOP_OFS);

    assign w_unused = &{1'b0, adr_i[1:0]};

    assign w_begin_full = {r_begin, 2'b00};
    assign w_end_full   = {r_end, 2'b00};
    assign w_begin_nxt  = wb_merge(w_begin_full, dat_i, sel_i);
    assign w_end_nxt    = wb_merge(w_end_full, dat_i, sel_i);

    // Read data selection
    always_comb begin
        w_rdata = '0;
        case (w_ofs)
            SIG_BEGIN_OFS: w_rdata = w_begin_full;
            SIG_END_OFS:   w_rdata = w_end_full;
            STATUS_OFS: begin
                w_rdata[STATUS_BUSY_BIT] = w_busy;
                w_rdata[STATUS_DONE_BIT] = w_done;
            end
            default:       w_rdata = '0;
        endcase
    end

    // Bus response and window registers; writes land on the edge that raises ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack   <= 1'b0;
            r_dat   <= '0;
            r_begin <= '0;
            r_end   <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !we_i) ? w_rdata : 32'd0;
            if (w_wr && (w_ofs == SIG_BEGIN_OFS)) r_begin <= w_begin_nxt[31:2];
            if (w_wr && (w_ofs == SIG_END_OFS))   r_end   <= w_end_nxt[31:2];
        end
    end

    sig_dumper #(
        .MEMORY_BASE_ADDRESS (MEMORY_BASE_ADDRESS),
        .MEMORY_SIZE         (MEMORY_SIZE)
    ) u_sig_dumper (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_start      (w_start),
        .i_begin      (w_begin_full),
        .i_end        (w_end_full),
        .o_mem_adr    (mem_adr_o),
        .i_mem_dat    (mem_dat_i),
        .o_sig_valid  (w_sig_valid),
        .o_sig_data_c (w_sig_data),
        .o_done       (w_done),
        .o_busy_c     (w_busy),
        .o_idle_c     (w_idle)
    );

    assign dat_o       = r_dat;
    assign ack_o       = r_ack;
    assign err_o       = 1'b0;
    assign rty_o       = 1'b0;
    assign sig_valid_o = w_sig_valid;
    assign sig_data_o  = w_sig_data;
    assign done_o      = w_done;

`ifdef CONTROL_SIM_DUMP_EN
    // Sampled mid-cycle so the combinational signature word is settled
    always @(negedge clk_i) begin
        if (sig_valid_o) $display("%08x", sig_data_o);
        if (done_o) $finish;
    end
`else
    // Synthesizable build: the signature leaves only through sig_valid_o/sig_data_o.
`endif

endmodule

// File: tb/tb_sim_control.sv
module tb_sim_control;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam logic [31:0] MBASE = 32'h2000_0000;
    localparam logic [31:0] MSIZE = 32'h0000_4000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i  = 1'b0;
    logic [31:0] adr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack_o, err_o, rty_o;
    logic [11:0] mem_adr_o;
    logic [31:0] mem_dat_i = '0;
    logic        sig_valid_o;
    logic [31:0] sig_data_o;
    logic        done_o;

    sim_control dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .we_i        (we_i),
        .adr_i       (adr_i),
        .sel_i       (sel_i),
        .dat_i       (dat_i),
        .dat_o       (dat_o),
        .ack_o       (ack_o),
        .err_o       (err_o),
        .rty_o       (rty_o),
        .mem_adr_o   (mem_adr_o),
        .mem_dat_i   (mem_dat_i),
        .sig_valid_o (sig_valid_o),
        .sig_data_o  (sig_data_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // RAM with one-cycle read latency
    logic [31:0] ram [0:4095];
    always @(posedge clk_i) mem_dat_i <= ram[mem_adr_o];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Reference model of the register file and dump
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_begin = '0;
    logic [31:0] m_end   = '0;
    bit          m_started = 1'b0;
    int          m_T = 0;
    int          m_words = 0;
    int          exp_done_cyc = -1;
    int          n_sig = 0;

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
        v[1:0] = 2'b00;
        return v;
    endfunction

    function automatic logic [31:0] exp_status(input int s);
        if (!m_started)            return 32'h0;
        if (s >= exp_done_cyc)     return 32'h2;
        if (s >= m_T)              return 32'h1;
        return 32'h0;
    endfunction

    task automatic model_start(input int t);
        logic [31:0] a, e, addr, off;
        int unsigned w;
        exp_t x;
        m_started = 1'b1;
        m_T = t;
        a = m_begin;
        e = m_end;
        w = (e > a) ? (e - a) / 4 : 0;
        m_words = int'(w);
        for (int unsigned k = 0; k < w; k++) begin
            addr = a + 32'(4 * k);
            if (addr >= MBASE && addr < MBASE + MSIZE) begin
                off = addr - MBASE;
                x.data = ram[off[13:2]];
            end else begin
                x.data = 32'h0;
            end
            x.cyc = t + 2 + int'(k);
            exp_q.push_back(x);
        end
        exp_done_cyc = (w == 0) ? t + 1 : t + 2 + int'(w);
    endtask

    // Monitor: pops expectations whenever the DUT presents a signature word
    bit prev_done = 1'b0;
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (rst_i) begin
            if (sig_valid_o) begin
                n_sig++;
                if (exp_q.size() == 0) begin
                    note_fail("sig_unexpected", sig_data_o, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("sig_data", sig_data_o, e.data);
                    check("sig_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done_o && !prev_done) check("done_cycle", 32'(cyc), 32'(exp_done_cyc));
            prev_done = done_o;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic wb_cycle(input bit we, input logic [31:0] adr, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] rd, output int t);
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = d; sel_i = s;
        t = -1;
        rd = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (ack_o) begin
                t = cyc;
                rd = dat_o;
                break;
            end
        end
        if (t < 0) note_fail("wb_ack_timeout", 32'h0, 32'h1);
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic reg_write(input logic [1:0] ofs, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        int t;
        wb_cycle(1'b1, BASE | {28'd0, ofs, 2'b00}, d, s, rd, t);
        if (!m_started && t >= 0) begin
            case (ofs)
                2'd0:    m_begin = merge(m_begin, d, s);
                2'd1:    m_end   = merge(m_end, d, s);
                2'd2:    model_start(t);
                default: ;
            endcase
        end
    endtask

    task automatic reg_check(input string name, input logic [1:0] ofs);
        logic [31:0] rd, exp;
        int t;
        wb_cycle(1'b0, BASE | {28'd0, ofs, 2'b00}, 32'h0, 4'hF, rd, t);
        case (ofs)
            2'd0:    exp = m_begin;
            2'd1:    exp = m_end;
            2'd3:    exp = exp_status(t - 1);
            default: exp = 32'h0;
        endcase
        if (t >= 0) check(name, rd, exp);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        exp_q.delete();
        exp_done_cyc = -1;
        m_begin = '0;
        m_end = '0;
        m_started = 1'b0;
        m_words = 0;
        n_sig = 0;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_dat_o", dat_o, 32'h0);
        check("rst_ack_o", {31'd0, ack_o}, 32'h0);
        check("rst_sig_valid", {31'd0, sig_valid_o}, 32'h0);
        check("rst_sig_data", sig_data_o, 32'h0);
        check("rst_done", {31'd0, done_o}, 32'h0);
        check("rst_mem_adr", {20'd0, mem_adr_o}, 32'h0);
        check("rst_err_rty", {30'd0, err_o, rty_o}, 32'h0);
        @(posedge clk_i); #2;
        rst_i = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done_o && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (!done_o) note_fail({name, "_done_timeout"}, 32'h0, 32'h1);
        @(negedge clk_i);
        check({name, "_words"}, 32'(n_sig), 32'(m_words));
        check({name, "_pending"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acks;
        int len;
        int mode;
        logic [31:0] b, e;

        for (int i = 0; i < 4096; i++) ram[i] = $urandom;
        ram[12'h040] = 32'd1;
        ram[12'h041] = 32'd2;
        ram[12'h042] = 32'd3;
        ram[12'h043] = 32'd4;

        do_reset();
        reg_check("begin_reset", 2'd0);
        reg_check("status_reset", 2'd3);

        // Register access and byte lanes
        reg_write(2'd0, 32'h2000_0100, 4'hF);
        reg_check("begin_full", 2'd0);
        reg_write(2'd0, 32'h0000_AB00, 4'b0010);
        reg_check("begin_byte", 2'd0);
        check("begin_byte_const", m_begin, 32'h2000_AB00);
        reg_write(2'd1, 32'hFFFF_FFFF, 4'hF);
        reg_check("end_lowbits", 2'd1);
        reg_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        reg_check("status_ro", 2'd3);
        reg_check("stop_read", 2'd2);

        // Held strobe: ack every other cycle, dat_o zero between acks
        @(posedge clk_i); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = BASE | 32'hC;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
            else check("dat_idle_zero", dat_o, 32'h0);
        end
        check("held_strobe_acks", 32'(acks), 32'd3);
        // Address outside the register window is not acked
        adr_i = BASE + 32'h10;
        @(posedge clk_i); #1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (ack_o) acks++;
        end
        check("unselected_acks", 32'(acks), 32'd0);
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0;

        // Four-word dump, then a late STOP and SIG_END write that must be ignored
        do_reset();
        reg_write(2'd0, 32'h2000_0100, 4'hF);
        reg_write(2'd1, 32'h2000_0110, 4'hF);
        reg_write(2'd2, 32'h0, 4'hF);
        reg_write(2'd2, 32'hDEAD_BEEF, 4'h1);
        reg_write(2'd1, 32'h2000_0200, 4'hF);
        wait_done("four");
        reg_check("four_status", 2'd3);
        reg_check("four_end_kept", 2'd1);

        // Empty window
        do_reset();
        reg_write(2'd0, 32'h2000_0000, 4'hF);
        reg_write(2'd1, 32'h2000_0000, 4'hF);
        reg_write(2'd2, 32'h0, 4'hF);
        wait_done("empty");
        reg_check("empty_status", 2'd3);

        // Window straddling the top of RAM
        do_reset();
        reg_write(2'd0, 32'h2000_3FFC, 4'hF);
        reg_write(2'd1, 32'h2000_4004, 4'hF);
        reg_write(2'd2, 32'h0, 4'hF);
        wait_done("top_edge");

        // Reset in the middle of a long dump
        do_reset();
        reg_write(2'd0, 32'h2000_0000, 4'hF);
        reg_write(2'd1, 32'h2000_00A0, 4'hF);
        reg_write(2'd2, 32'h0, 4'hF);
        repeat (5) @(posedge clk_i);
        #3;
        do_reset();
        repeat (10) @(negedge clk_i);
        check("abort_done", {31'd0, done_o}, 32'h0);
        check("abort_no_words", 32'(n_sig), 32'h0);
        reg_check("abort_begin", 2'd0);
        reg_check("abort_status", 2'd3);

        // Randomized windows
        for (int r = 0; r < 14; r++) begin
            do_reset();
            mode = int'($urandom_range(0, 3));
            len  = int'($urandom_range(0, 24));
            case (mode)
                0:       b = MBASE + 32'($urandom_range(0, 4095)) * 32'd4;
                1:       b = MBASE + MSIZE - 32'($urandom_range(0, 8)) * 32'd4;
                2:       b = MBASE - 32'($urandom_range(0, 8)) * 32'd4;
                default: b = 32'h1000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
            endcase
            if ($urandom_range(0, 5) == 0) e = b - 32'($urandom_range(0, 4)) * 32'd4;
            else                           e = b + 32'(len) * 32'd4 + 32'($urandom_range(0, 3));
            reg_write(2'd0, $urandom, 4'hF);
            reg_write(2'd0, b, 4'b0011);
            reg_write(2'd0, b, 4'b1100);
            reg_write(2'd1, e, 4'hF);
            reg_check("rnd_begin", 2'd0);
            reg_check("rnd_end", 2'd1);
            reg_write(2'd2, $urandom, 4'($urandom_range(0, 15)));
            reg_check("rnd_status_run", 2'd3);
            reg_write(2'd2, 32'h0, 4'hF);
            reg_write(2'd1, $urandom, 4'hF);
            wait_done("rnd");
            reg_check("rnd_status_done", 2'd3);
            reg_check("rnd_end_kept", 2'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
